// File: rtl/spi_flash_slave_if.sv
// Serial pins and status outputs shared between an SPI master and the flash-style slave.
interface spi_flash_slave_if;
    logic       cs_n;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       busy;
    logic [7:0] cmd;
    logic       wr_done;
    logic       rd_done;
    logic       frame_abort;

    modport slave (
        input  cs_n, sclk, mosi,
        output miso, busy, cmd, wr_done, rd_done, frame_abort
    );

    modport master (
        output cs_n, sclk, mosi,
        input  miso, busy, cmd, wr_done, rd_done, frame_abort
    );
endinterface

// File: rtl/spi_flash_slave.sv
// SPI mode-0 slave with a small word store: cmd(8) + addr(24) + data(32) frames,
// SCLK oversampled on the system clock.
module spi_flash_slave #(
    parameter int         MEM_WORDS = 16,
    parameter logic [7:0] CMD_WRITE = 8'h02,
    parameter logic [7:0] CMD_READ  = 8'h03
) (
    input  logic               clk,
    input  logic               rst,
    spi_flash_slave_if.slave   bus
);
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [1:0]       r_sclk_s, r_mosi_s, r_cs_s;
    logic             r_sclk_d;
    logic [5:0]       r_cnt;
    logic [30:0]      r_shift;
    logic [31:0]      r_tx;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_cmd;
    logic             r_miso, r_wr_done, r_rd_done, r_abort;
    logic [31:0]      r_mem [MEM_WORDS];

    logic             w_rise, w_fall, w_cs_hi, w_mosi, w_shifting, w_last;
    logic [IDX_W-1:0] w_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_s <= 2'b00;
            r_mosi_s <= 2'b00;
            r_cs_s   <= 2'b11;
            r_sclk_d <= 1'b0;
        end else begin
            r_sclk_s <= {r_sclk_s[0], bus.sclk};
            r_mosi_s <= {r_mosi_s[0], bus.mosi};
            r_cs_s   <= {r_cs_s[0], bus.cs_n};
            r_sclk_d <= r_sclk_s[1];
        end
    end

    assign w_rise     = r_sclk_s[1] & ~r_sclk_d;
    assign w_fall     = ~r_sclk_s[1] & r_sclk_d;
    assign w_cs_hi    = r_cs_s[1];
    assign w_mosi     = r_mosi_s[1];
    assign w_shifting = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_last     = (r_state == S_DATA) && w_rise && (r_cnt == 6'd63);
    // Address bit 0 is the incoming bit, so word index bits sit one place lower in the shifter.
    assign w_idx      = r_shift[IDX_W:1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (!w_cs_hi) w_next = S_CMD;
            S_CMD:  if (w_cs_hi) w_next = S_IDLE;
                    else if (w_rise && r_cnt == 6'd7) w_next = S_ADDR;
            S_ADDR: if (w_cs_hi) w_next = S_IDLE;
                    else if (w_rise && r_cnt == 6'd31) w_next = S_DATA;
            // The final rise wins over a simultaneous cs_n release.
            S_DATA: if (w_last) w_next = S_DONE;
                    else if (w_cs_hi) w_next = S_IDLE;
            S_DONE: if (w_cs_hi) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_tx      <= '0;
            r_idx     <= '0;
            r_cmd     <= '0;
            r_miso    <= 1'b0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
            r_abort   <= 1'b0;
            for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
        end else begin
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
            r_abort   <= 1'b0;
            if (w_next == S_IDLE && r_state != S_IDLE) begin
                r_cnt  <= '0;
                r_miso <= 1'b0;
                if (r_state != S_DONE && r_cnt != 6'd0) r_abort <= 1'b1;
            end else if (w_rise && w_shifting) begin
                r_cnt   <= r_cnt + 6'd1;
                r_shift <= {r_shift[29:0], w_mosi};
                if (r_state == S_CMD && r_cnt == 6'd7) r_cmd <= {r_shift[6:0], w_mosi};
                if (r_state == S_ADDR && r_cnt == 6'd31) begin
                    r_idx <= w_idx;
                    r_tx  <= r_mem[w_idx];
                end
                if (w_last) begin
                    r_miso <= 1'b0;
                    if (r_cmd == CMD_WRITE) begin
                        r_mem[r_idx] <= {r_shift, w_mosi};
                        r_wr_done    <= 1'b1;
                    end
                    if (r_cmd == CMD_READ) r_rd_done <= 1'b1;
                end
            end else if (w_fall && r_state == S_DATA && r_cmd == CMD_READ) begin
                r_miso <= r_tx[31];
                r_tx   <= {r_tx[30:0], 1'b0};
            end
        end
    end

    assign bus.miso        = r_miso;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.cmd         = r_cmd;
    assign bus.wr_done     = r_wr_done;
    assign bus.rd_done     = r_rd_done;
    assign bus.frame_abort = r_abort;
endmodule

// File: tb/tb_spi_flash_slave.sv
// Drives SPI frames into spi_flash_slave and checks it against a word-level store model.
module tb_spi_flash_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_flash_slave_if u_if();

    spi_flash_slave #(.MEM_WORDS(16), .CMD_WRITE(8'h02), .CMD_READ(8'h03)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (u_if)
    );

    int n_chk = 0;
    int n_err = 0;

    // Pulse monitor: counts pulses and flags any pulse longer than one cycle
    // or an abort seen while busy is still high.
    int   wr_seen = 0, rd_seen = 0, ab_seen = 0, bad_seen = 0;
    logic p_wr = 1'b0, p_rd = 1'b0, p_ab = 1'b0;
    always @(negedge clk) begin
        if (u_if.wr_done) wr_seen <= wr_seen + 1;
        if (u_if.rd_done) rd_seen <= rd_seen + 1;
        if (u_if.frame_abort) ab_seen <= ab_seen + 1;
        if ((u_if.wr_done && p_wr) || (u_if.rd_done && p_rd) || (u_if.frame_abort && p_ab) ||
            (u_if.frame_abort && u_if.busy))
            bad_seen <= bad_seen + 1;
        p_wr <= u_if.wr_done;
        p_rd <= u_if.rd_done;
        p_ab <= u_if.frame_abort;
    end

    logic [31:0] mem_m [16];
    logic [7:0]  cmd_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_miso", {31'b0, u_if.miso}, 32'd0);
        chk("rst_busy", {31'b0, u_if.busy}, 32'd0);
        chk("rst_cmd", {24'b0, u_if.cmd}, 32'd0);
        chk("rst_pulses", {29'b0, u_if.wr_done, u_if.rd_done, u_if.frame_abort}, 32'd0);
    endtask

    // One frame of nbits SCLK cycles; rst_at >= 0 asserts reset before that bit's rise.
    task automatic frame(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d,
                         input int nbits, input int rst_at, output logic [31:0] rx);
        logic [63:0] bits;
        logic [31:0] exp_word;
        logic        exp_m;
        int          idx, w0, r0, a0;
        bits = {c, a, d};
        idx  = int'(a[5:2]);
        exp_word = mem_m[idx];
        rx = 32'd0;
        w0 = wr_seen; r0 = rd_seen; a0 = ab_seen;
        u_if.cs_n = 1'b0;
        tick(5);
        chk("busy_hi", {31'b0, u_if.busy}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            u_if.mosi = (i < 64) ? bits[63-i] : 1'($urandom_range(0, 1));
            tick(5);
            exp_m = (c == 8'h03 && i >= 32 && i < 64) ? exp_word[63-i] : 1'b0;
            chk($sformatf("miso_bit%0d", i), {31'b0, u_if.miso}, {31'b0, exp_m});
            if (i >= 32 && i < 64) rx[63-i] = u_if.miso;
            if (i == rst_at) begin
                rst_n = 1'b0;
                tick(2);
                chk_reset_outputs();
                for (int k = 0; k < 16; k++) mem_m[k] = 32'd0;
                cmd_m = 8'h00;
                u_if.cs_n = 1'b1;
                u_if.sclk = 1'b0;
                tick(3);
                rst_n = 1'b1;
                tick(4);
                chk("rst_no_pulse", wr_seen + rd_seen + ab_seen - w0 - r0 - a0, 32'd0);
                return;
            end
            u_if.sclk = 1'b1;
            tick(5);
            u_if.sclk = 1'b0;
        end
        tick(5);
        u_if.cs_n = 1'b1;
        tick(6);
        if (nbits >= 8) cmd_m = c;
        if (nbits >= 64 && c == 8'h02) mem_m[idx] = d;
        chk("wr_pulses", wr_seen - w0, (nbits >= 64 && c == 8'h02) ? 1 : 0);
        chk("rd_pulses", rd_seen - r0, (nbits >= 64 && c == 8'h03) ? 1 : 0);
        chk("abort_pulses", ab_seen - a0, (nbits >= 1 && nbits < 64) ? 1 : 0);
        chk("pulse_shape", bad_seen, 32'd0);
        chk("cmd", {24'b0, u_if.cmd}, {24'b0, cmd_m});
        chk("busy_lo", {31'b0, u_if.busy}, 32'd0);
        chk("miso_idle", {31'b0, u_if.miso}, 32'd0);
    endtask

    initial begin
        logic [31:0] rx;
        logic [7:0]  c;
        int          nb, sel;
        u_if.cs_n = 1'b1;
        u_if.sclk = 1'b0;
        u_if.mosi = 1'b0;
        for (int k = 0; k < 16; k++) mem_m[k] = 32'd0;
        cmd_m = 8'h00;
        tick(3);
        chk_reset_outputs();
        rst_n = 1'b1;
        tick(4);

        // write then read
        frame(8'h02, 24'h000008, 32'h96AAE959, 64, -1, rx);
        frame(8'h03, 24'h000008, 32'h0, 64, -1, rx);
        chk("lit_write_read", rx, 32'h96AAE959);

        // aliasing: 0x4C and 0x0C both hit word 3
        frame(8'h02, 24'h00004C, 32'hAAAAAAAA, 64, -1, rx);
        frame(8'h03, 24'h00000C, 32'h0, 64, -1, rx);
        chk("lit_alias", rx, 32'hAAAAAAAA);
        frame(8'h03, 24'h000010, 32'h0, 64, -1, rx);
        chk("lit_idx4", rx, 32'h0);

        // unknown command
        frame(8'h69, 24'h2AAAAC, 32'hFFFFFFFF, 64, -1, rx);
        chk("lit_cmd69", {24'b0, u_if.cmd}, 32'h69);
        frame(8'h03, 24'h2AAAAC, 32'h0, 64, -1, rx);
        chk("lit_unknown_nostore", rx, 32'h0);

        // early release after 40 bits
        frame(8'h02, 24'h000008, 32'h12345678, 40, -1, rx);
        frame(8'h03, 24'h000008, 32'h0, 64, -1, rx);
        chk("lit_abort_keep", rx, 32'h96AAE959);

        // overlength write
        frame(8'h02, 24'h000014, 32'hCAFEF00D, 72, -1, rx);
        frame(8'h03, 24'h000014, 32'h0, 64, -1, rx);
        chk("lit_overlength", rx, 32'hCAFEF00D);

        // reset in the middle of a read
        frame(8'h03, 24'h000008, 32'h0, 64, 50, rx);
        frame(8'h03, 24'h000008, 32'h0, 64, -1, rx);
        chk("lit_after_reset", rx, 32'h0);

        for (int n = 0; n < 50; n++) begin
            sel = $urandom_range(0, 3);
            c = (sel == 0) ? 8'h02 : (sel == 1) ? 8'h03 : 8'($urandom);
            sel = $urandom_range(0, 9);
            nb = (sel < 7) ? 64 : (sel == 7) ? 64 + $urandom_range(1, 8) : $urandom_range(1, 63);
            frame(c, 24'($urandom), $urandom, nb, -1, rx);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/spi_flash_slave.md
# spi_flash_slave

Behavioural-synthesizable SPI slave that sits directly downstream of the `spi` master: it consumes the master's SCLK/MOSI serial frames (8-bit command, 24-bit address, 32-bit data) and drives MISO back. It decodes write and read commands against an internal 16×32 word store. It gives the master's bench a real target and gives the design a register-file endpoint. All logic runs on the system clock; SCLK is oversampled, never used as a clock.

## Interface

Parameters:
- `MEM_WORDS`, 16: number of 32-bit words in the store. Must be a power of two.
- `CMD_WRITE`, 8'h02: command code for a word write.
- `CMD_READ`, 8'h03: command code for a word read.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cs_n`  in  1  chip select, active-low, asynchronous to `clk`.
- `sclk`  in  1  serial clock from the master, asynchronous. Frequency must be ≤ `clk`/4; each high and low phase must be ≥ 2 `clk` periods.
- `mosi`  in  1  serial data from the master.
- `miso`  out  1  serial data to the master.
- `busy`  out  1  high while a frame is in progress (any state other than IDLE).
- `cmd`  out  8  last fully received command byte; held until the next command completes.
- `wr_done`  out  1  one-`clk` pulse when a write commits to the store.
- `rd_done`  out  1  one-`clk` pulse when the 32nd read bit has been shifted out.
- `frame_abort`  out  1  one-`clk` pulse when `cs_n` rises before bit 64 of a frame.

## Operation

- **Input synchronization:** `sclk`, `mosi` and `cs_n` each pass through a 2-flop synchronizer.
  - SCLK rise and fall are detected by comparing the synchronized value with its previous sample.
  - SPI mode 0, MSB first: MOSI is sampled on the detected SCLK rise; MISO is updated on the detected SCLK fall.
- **State machine:** IDLE → CMD (8 bits) → ADDR (24 bits) → DATA (32 bits) → DONE. A 6-bit bit counter runs across the whole frame.
  - IDLE → CMD: when synchronized `cs_n` is low.
  - CMD → ADDR: on the 8th rise. `cmd` is updated at this point.
  - ADDR → DATA: on the 32nd rise. The word index `idx = address[log2(MEM_WORDS)+1:2]`; `address[1:0]` and the upper bits are ignored, so addresses alias modulo `MEM_WORDS*4`.
  - DATA → DONE: on the 64th rise.
  - DONE: all further SCLK edges are ignored and `miso` holds 0 until `cs_n` rises, then the block returns to IDLE.
  - Any state with synchronized `cs_n` high: return to IDLE and clear the counter. `frame_abort` pulses if the counter was between 1 and 63.
- **Write** (`cmd == CMD_WRITE`): the 32 data bits are shifted in. On the 64th rise the word is written to `mem[idx]` and `wr_done` pulses. An aborted write leaves the store unchanged.
- **Read** (`cmd == CMD_READ`):
  - On the 32nd rise, `mem[idx]` is loaded into the shift register.
  - On the following SCLK fall, `miso` is driven with bit 31, and then with the next lower bit on each fall after that.
  - `rd_done` pulses on the 64th rise.
- **Any other command:** the data bits are consumed and discarded, `miso` stays 0, and neither done pulse fires.
- **Outside the read data phase:** `miso` is 0.
- **Reset values:** `miso`=0, `busy`=0, `cmd`=8'h00, `wr_done`=`rd_done`=`frame_abort`=0, state IDLE, counter 0, all store words 32'h0.
- **Reset asserted mid-frame:** immediate return to the reset values, with the store cleared. The frame in progress is lost; no pulse is emitted.

## Timing

- **Edge detection latency:** a detected SCLK edge occurs 2–3 `clk` cycles after the pin transition.
- **`miso` update:** `miso` is registered and changes on the `clk` edge after the SCLK fall is detected, i.e. ≤ 4 `clk` after the pin falls. This is valid before the next SCLK rise given the ≥ 2-cycle phase rule.
- **Done pulses:** `wr_done` and `rd_done` assert on the `clk` edge that processes the 64th rise and last exactly 1 cycle.
- **Write visibility:** the store is updated on the same edge as `wr_done`. A read frame starting afterwards sees the new value.
- **`busy`:** rises 2–3 `clk` cycles after `cs_n` falls and falls 2–3 cycles after `cs_n` rises.
- **`frame_abort`:** asserts on the same edge on which `busy` falls.
- **`cs_n` rise coinciding with the 64th rise detection:** the rise is processed first; the frame completes and the done pulse fires, with no abort.

## Test plan

- **Write then read:** write cmd 8'h02, address 24'h000008, data 32'h96AAE959; then read cmd 8'h03, same address. Expect `wr_done` 1 pulse, then `miso` serializes 32'h96AAE959 MSB first and `rd_done` pulses.
- **Address aliasing:** write 32'hAAAAAAAA to address 24'h00004C (idx 3); read address 24'h00000C. Expect `miso` = 32'hAAAAAAAA. A read of idx 4 returns 32'h0.
- **Unknown command:** cmd 8'h69, address 24'h2AAAAC, data 32'hFFFFFFFF. Expect `miso` 0 throughout, no done pulses, `cmd`=8'h69, store unchanged.
- **Early cs_n release:** raise `cs_n` after 40 bits of a write. Expect `frame_abort` 1 pulse, no `wr_done`, the word still at its old value, and `busy` low.
- **Overlength frame:** send 72 SCLK cycles on a write. Expect commit at bit 64, bits 65–72 ignored, no abort on `cs_n` rise.
- **Reset mid-read:** assert `rst` low at bit 50 of a read. Expect all outputs at reset values, then a fresh read returning 32'h0.
